pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, replacing the fixed-field, stall-vector-driven stage registers between decode, execute, memory and writeback. It carries an opaque payload of configurable width, applies backpressure, and inserts a bubble (the configured NOP payload) on flush or underflow. An optional two-entry skid buffer makes `in_ready` a registered signal, which breaks the combinational ready path through the pipeline. A saturating stall counter exposes how often each stage is backpressured.

## Interface
- `DATA_W`, default 64: payload width in bits; must be ≥ 1.
- `NOP_VALUE`, default `{DATA_W{1'b0}}`: payload driven whenever the stage holds no valid entry (bubble encoding).
- `CNT_W`, default 32: width of the stall counter.

- `clk`  in  1: the single clock; everything is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: synchronous kill of every held entry.
- `in_valid`  in  1: upstream payload valid.
- `in_ready`  out  1: stage accepts the payload this cycle.
- `in_data`  in  DATA_W: upstream payload.
- `out_valid`  out  1: downstream payload valid.
- `out_ready`  in  1: downstream accepts the payload this cycle.
- `out_data`  out  DATA_W: downstream payload; equals `NOP_VALUE` when `out_valid` is 0.
- `occupancy`  out  2: number of held entries (0..2).
- `stall_cnt`  out  CNT_W: count of cycles with `out_valid && !out_ready`; saturates.

## Operation
- A transfer happens on each side when valid and ready are both 1 in the same cycle.
- The stage has a main entry that drives `out_data`, plus a skid entry when `PIPE_STAGE_SKID_EN` is defined.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - TWO: main and skid valid; exists only in skid mode.
- EMPTY: accept → ONE, and main ← `in_data`.
- ONE:
  - output only → EMPTY.
  - input and output together → ONE, with main ← `in_data`.
  - input only → TWO, with skid ← `in_data` (skid mode only).
  - neither → hold.
- TWO: `in_ready` is 0. When the output transfers, main ← skid and the state goes to ONE.
- Data is never reordered, duplicated or dropped, except on flush or reset.
- `flush` takes priority over every handshake:
  - Next state is EMPTY and `out_data` becomes `NOP_VALUE`.
  - A payload offered in the flush cycle is discarded, even if `in_ready` was 1.
  - An output transfer in the flush cycle still counts as delivered.
- `stall_cnt` increments on every cycle with `out_valid && !out_ready`, holds at all-ones, and is unaffected by `flush`.
- `rst` overrides `flush` and all handshakes.

## Timing
- Reset values: `out_valid` 0, `out_data` = `NOP_VALUE`, `occupancy` 0, `stall_cnt` 0. `in_ready` is forced to 0 while `rst` is high.
- Latency is 1 cycle. Data accepted at edge N appears on `out_data` with `out_valid` after edge N.
- Throughput is 1 transfer per cycle in both modes when `out_ready` stays high.
- Skid mode: `in_ready` = !skid valid && !`rst`. It is a pure register decode with no combinational path from `out_ready`.
- Non-skid mode: `in_ready` = (!`out_valid` || `out_ready`) && !`rst`, which is combinational from `out_ready`.
- Reset mid-operation: all held entries are lost, and the first legal accept is in the cycle after `rst` deasserts.
- `out_valid` and `out_data` must stay stable while `out_valid && !out_ready`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Two-entry skid buffer; state TWO is reachable.
  - Registered `in_ready`; `occupancy` ranges 0..2.
- `PIPE_STAGE_SKID_EN` undefined:
  - Single entry; `occupancy` is 0..1 and bit 1 is tied to 0.
  - `in_ready` is combinational from `out_ready`.
  - Reduces to the classic bubble-inserting stage register.

## Test plan
- Reset, then 0xA5 offered with `in_valid`=1 and `out_ready`=1 every cycle → `out_data`=0xA5 with `out_valid` one cycle later; continuous 1/cycle streaming of 0x1..0x8 arrives in order with no gaps.
- Skid mode, `out_ready`=0 while offering 0x11, 0x22, 0x33 → 0x11 and 0x22 are accepted, `occupancy`=2, `in_ready`=0 and 0x33 is held upstream. Raising `out_ready` yields 0x11, 0x22, 0x33 in order, and `stall_cnt` equals the number of held cycles.
- Non-skid mode, same stimulus → only 0x11 is accepted, `occupancy`=1, and `in_ready` follows `out_ready` combinationally in the same cycle.
- `flush` asserted in state TWO while 0x44 is offered → next cycle `out_valid`=0, `out_data`=`NOP_VALUE`, `occupancy`=0, and 0x44 is never output.
- `rst` asserted mid-stream with `stall_cnt`=5 → next cycle every output equals its reset value and `stall_cnt`=0. With `CNT_W`=3, holding a stall for 10 cycles → `stall_cnt` saturates at 7.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble insertion and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] main_q, main_nx;
  logic [CNT_W-1:0]  stall_q;
  logic              in_fire, out_fire;

  assign out_valid = (state != S_EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign stall_cnt = stall_q;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_nx;

  // Decoded from state only, so no path from out_ready.
  assign in_ready  = (state != S_TWO) && !rst;
  assign occupancy = state;
`else
  assign in_ready  = (!out_valid || out_ready) && !rst;
  assign occupancy = {1'b0, out_valid};
`endif

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_nx  = skid_q;
`endif
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (in_fire) begin
            state_nx = S_ONE;
            main_nx  = in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_nx = in_data;
          end else if (out_fire) begin
            state_nx = S_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            state_nx = S_TWO;
            skid_nx  = in_data;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        S_TWO: begin
          if (out_fire) begin
            state_nx = S_ONE;
            main_nx  = skid_q;
          end
        end
`endif
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      main_q <= NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
      skid_q <= NOP_VALUE;
`endif
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
`ifdef PIPE_STAGE_SKID_EN
      skid_q <= skid_nx;
`endif
    end
  end

  // Saturating backpressure counter; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule
